// File: rtl/ofm_wdma_burst_scheduler.sv
// OFM write-DMA burst scheduler: turns the OFM buffer beat stream into AXI4
// write bursts (AW, W/WLAST, B), never crossing a 4 KB page and keeping at
// most MAX_OUTSTANDING bursts in flight. Status via busy/done/err.
// Optional build macro OFM_WDMA_PERF_CNT_EN adds perf_cycles/perf_stall.
module ofm_wdma_burst_scheduler #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 64,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ap_start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [31:0]       transfer_byte,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [7:0]        m_awlen,
    output logic              m_wvalid,
    input  logic              m_wready,
    output logic [DATA_W-1:0] m_wdata,
    output logic              m_wlast,
    input  logic              m_bvalid,
    output logic              m_bready,
    input  logic [1:0]        m_bresp,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef OFM_WDMA_PERF_CNT_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stall
`endif
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_ADDR, S_DATA, S_WAITB, S_FIN} state_t;

    state_t            state, state_nxt;
    logic              ap_start_q;
    logic [ADDR_W-1:0] addr;
    logic [28:0]       remaining;
    logic [OUT_W-1:0]  outstanding;
    logic [7:0]        beat_cnt;
    logic [8:0]        burst_len;
    logic [12:0]       bound_beats;
    logic [28:0]       len_w;
    logic              start_edge, aw_hs, w_hs, b_hs, b_ok;
    logic              unused_low_bits;

    // byte count is beat-granular; sub-beat bits carry no meaning
    assign unused_low_bits = ^transfer_byte[2:0];

    assign start_edge  = (state == S_IDLE) && ap_start && !ap_start_q;
    assign aw_hs       = m_awvalid && m_awready;
    assign w_hs        = m_wvalid && m_wready;
    assign b_hs        = m_bvalid && m_bready;
    assign b_ok        = b_hs && (outstanding != '0);
    assign bound_beats = (13'd4096 - {1'b0, addr[11:0]}) >> 3;

    // burst length: smallest of burst cap, beats left and beats to the 4 KB page end
    always_comb begin
        len_w = 29'(MAX_BURST);
        if (remaining < len_w) len_w = remaining;
        if ({16'd0, bound_beats} < len_w) len_w = {16'd0, bound_beats};
    end

    // next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        s_ready   = 1'b0;
        m_wdata   = '0;
        m_wlast   = 1'b0;
        busy      = (state != S_IDLE);
        m_bready  = (state != S_IDLE);
        done      = (state == S_FIN);
        unique case (state)
            S_IDLE:  if (start_edge) state_nxt = S_CALC;
            S_CALC:  state_nxt = (remaining == '0) ? S_FIN : S_ADDR;
            S_ADDR: begin
                m_awvalid = (outstanding != OUT_W'(MAX_OUTSTANDING));
                if (aw_hs) state_nxt = S_DATA;
            end
            S_DATA: begin
                m_wvalid = s_valid;
                s_ready  = m_wready;
                m_wdata  = s_data;
                m_wlast  = (beat_cnt == m_awlen);
                if (w_hs && m_wlast) state_nxt = (remaining != '0) ? S_CALC : S_WAITB;
            end
            S_WAITB: if (outstanding == '0) state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // state, address/length bookkeeping, outstanding count and error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ap_start_q  <= 1'b0;
            addr        <= '0;
            remaining   <= '0;
            outstanding <= '0;
            beat_cnt    <= '0;
            burst_len   <= '0;
            m_awaddr    <= '0;
            m_awlen     <= '0;
            err         <= 1'b0;
        end else begin
            state      <= state_nxt;
            ap_start_q <= ap_start;
            if (start_edge) begin
                addr      <= base_addr;
                remaining <= transfer_byte[31:3];
            end
            if (state == S_CALC && remaining != '0) begin
                m_awaddr  <= addr;
                m_awlen   <= 8'(len_w - 29'd1);
                burst_len <= len_w[8:0];
            end
            if (aw_hs) begin
                addr      <= addr + ADDR_W'({burst_len, 3'b000});
                remaining <= remaining - 29'(burst_len);
                beat_cnt  <= '0;
            end else if (w_hs) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
            // simultaneous AW and accepted B cancel out
            if (aw_hs && !b_ok)      outstanding <= outstanding + OUT_W'(1);
            else if (!aw_hs && b_ok) outstanding <= outstanding - OUT_W'(1);
            // an unsolicited B is dropped but flagged
            if (start_edge)
                err <= 1'b0;
            else if (b_hs && (m_bresp != 2'b00 || outstanding == '0))
                err <= 1'b1;
        end
    end

`ifdef OFM_WDMA_PERF_CNT_EN
    // saturating busy-cycle and stall counters, cleared on each start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (start_edge) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
            if (((state == S_DATA && s_valid && !m_wready) || (m_awvalid && !m_awready))
                && perf_stall != '1)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ofm_wdma_burst_scheduler.sv
// Bench for ofm_wdma_burst_scheduler: directed transfers plus random ones,
// checked against a burst-list reference model and an AXI slave model.
module tb_ofm_wdma_burst_scheduler;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int MAX_BURST = 16;
    localparam int MAX_OUT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ap_start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [31:0] transfer_byte = '0;
    logic s_valid = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic s_ready;
    logic m_awvalid;
    logic m_awready = 1'b0;
    logic [ADDR_W-1:0] m_awaddr;
    logic [7:0] m_awlen;
    logic m_wvalid;
    logic m_wready = 1'b0;
    logic [DATA_W-1:0] m_wdata;
    logic m_wlast;
    logic m_bvalid = 1'b0;
    logic m_bready;
    logic [1:0] m_bresp = 2'b00;
    logic busy, done, err;
`ifdef OFM_WDMA_PERF_CNT_EN
    logic [31:0] perf_cycles, perf_stall;
`endif

    ofm_wdma_burst_scheduler #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ap_start(ap_start), .base_addr(base_addr),
        .transfer_byte(transfer_byte), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .busy(busy), .done(done), .err(err)
`ifdef OFM_WDMA_PERF_CNT_EN
        , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    // reference model: expected burst list for the current transfer
    logic [31:0] exp_addr[$];
    int          exp_len[$];
    logic [1:0]  b_pend[$];
    int total = 0, aw_i = 0, w_i = 0, wb = 0, wbeat = 0, b_cnt = 0, src_idx = 0;
    int done_cnt = 0, done_cyc = 0, start_cyc = 0, err_burst = 999;
    bit rnd = 0, b_en = 1, aw_seen = 0, exp_err = 0;
    logic [31:0] tag = 32'h0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input int i);
        return {tag, 32'(i)};
    endfunction

    task automatic build_model(input logic [31:0] base, input logic [31:0] bytes);
        int rem, n, room;
        logic [31:0] a;
        exp_addr.delete();
        exp_len.delete();
        rem = int'(bytes >> 3);
        a = base;
        while (rem > 0) begin
            n = (rem < MAX_BURST) ? rem : MAX_BURST;
            room = (4096 - int'(a % 4096)) / 8;
            if (room < n) n = room;
            exp_addr.push_back(a);
            exp_len.push_back(n);
            a = a + 32'(n * 8);
            rem -= n;
        end
    endtask

    always @(posedge clk) cyc++;

    // slave and source drivers, updated just after each rising edge
    always @(posedge clk) begin
        #1;
        m_awready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        m_wready  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        s_valid   = (src_idx < total) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
        s_data    = mk(src_idx);
        if (b_en && b_pend.size() > 0 && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1)) begin
            m_bvalid = 1'b1;
            m_bresp  = b_pend[0];
        end else begin
            m_bvalid = 1'b0;
            m_bresp  = 2'b00;
        end
    end

    // monitor: handshakes resolved on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (aw_i - b_cnt == MAX_OUT) chk("aw_limit", m_awvalid, 0);
            if (m_awvalid) aw_seen = 1;
            if (m_awvalid && m_awready) begin
                if (aw_i < exp_addr.size()) begin
                    chk("awaddr", m_awaddr, exp_addr[aw_i]);
                    chk("awlen", m_awlen, exp_len[aw_i] - 1);
                end else chk("aw_extra", aw_i, exp_addr.size());
                aw_i++;
            end
            if (m_wvalid && m_wready) begin
                if (wb < exp_len.size()) begin
                    chk("wdata", m_wdata, mk(w_i));
                    chk("wlast", m_wlast, wbeat == exp_len[wb] - 1);
                    if (wbeat == exp_len[wb] - 1) begin
                        b_pend.push_back((wb == err_burst) ? 2'b10 : 2'b00);
                        wb++;
                        wbeat = 0;
                    end else wbeat++;
                end else chk("w_extra", w_i, total);
                w_i++;
            end
            if (s_valid && s_ready) src_idx++;
            if (m_bvalid && m_bready && b_pend.size() > 0) begin
                void'(b_pend.pop_front());
                b_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_busy", busy, 1);
                chk("done_bcnt", b_cnt, exp_addr.size());
                chk("done_err", err, exp_err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_idle(input string pfx);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_err"}, err, 0);
        chk({pfx, "_awvalid"}, m_awvalid, 0);
        chk({pfx, "_awaddr"}, m_awaddr, 0);
        chk({pfx, "_awlen"}, m_awlen, 0);
        chk({pfx, "_wvalid"}, m_wvalid, 0);
        chk({pfx, "_wlast"}, m_wlast, 0);
        chk({pfx, "_wdata"}, m_wdata, 0);
        chk({pfx, "_bready"}, m_bready, 0);
        chk({pfx, "_sready"}, s_ready, 0);
    endtask

    task automatic start_xfer(input logic [31:0] base, input logic [31:0] bytes,
                              input int err_b, input bit rnd_mode, input bit hold_b);
        build_model(base, bytes);
        total = int'(bytes >> 3);
        aw_i = 0; w_i = 0; wb = 0; wbeat = 0; b_cnt = 0; src_idx = 0;
        done_cnt = 0; aw_seen = 0;
        err_burst = err_b;
        rnd = rnd_mode;
        b_en = !hold_b;
        tag = $urandom;
        b_pend.delete();
        exp_err = (err_b < exp_addr.size());
        base_addr = base;
        transfer_byte = bytes;
        ap_start = 1'b1;
        start_cyc = cyc;
        tick();
        ap_start = 1'b0;
        chk("err_clr", err, 0);
        chk("busy_on", busy, 1);
    endtask

    task automatic run_xfer(input logic [31:0] base, input logic [31:0] bytes,
                            input int err_b, input bit rnd_mode, input bit hold_b);
        int t;
        start_xfer(base, bytes, err_b, rnd_mode, hold_b);
        if (hold_b) begin
            t = 0;
            while (aw_i < MAX_OUT && t < 2000) begin tick(); t++; end
            repeat (30) tick();
            chk("aw_stall", aw_i, MAX_OUT);
            chk("stall_busy", busy, 1);
            b_en = 1;
        end
        t = 0;
        while (done_cnt == 0 && t < 5000) begin tick(); t++; end
        if (done_cnt == 0) chk("timeout", 0, 1);
        repeat (3) tick();
        chk("done_once", done_cnt, 1);
        chk("busy_off", busy, 0);
        chk("aw_count", aw_i, exp_addr.size());
        chk("w_count", w_i, total);
        chk("b_count", b_cnt, exp_addr.size());
        chk("err_hold", err, exp_err);
        if (total == 0) begin
            chk("zero_lat", done_cyc - start_cyc, 2);
            chk("zero_noaw", aw_seen, 0);
        end
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        repeat (3) tick();
        chk_idle("rst");
        rst_n = 1'b1;
        tick();

        run_xfer(32'h1000_0000, 32'd1024, 999, 0, 0);
        run_xfer(32'h1000_0FC0, 32'd640, 999, 0, 0);
        run_xfer(32'h1000_0000, 32'd200, 999, 0, 0);
        run_xfer(32'h1000_0000, 32'd0, 999, 0, 0);
        run_xfer(32'h1000_0000, 32'd1024, 999, 0, 1);
        run_xfer(32'h3000_0F00, 32'd1024, 2, 1, 0);
        for (int k = 0; k < 4; k++)
            run_xfer($urandom & 32'hFFFF_FFF8, $urandom_range(0, 2000), 999, 1, 0);

        // reset in the middle of a data phase
        start_xfer(32'h1000_0000, 32'd1024, 999, 0, 0);
        t = 0;
        while (w_i < 20 && t < 2000) begin tick(); t++; end
        chk("mid_in_data", m_wvalid, 1);
        rst_n = 1'b0;
        b_en = 0;
        tick();
        chk_idle("midrst");
        rst_n = 1'b1;
        total = 0;
        tick();
        run_xfer(32'h2000_0000, 32'd64, 999, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ofm_wdma_burst_scheduler.md
Name: ofm_wdma_burst_scheduler

Overview:
- Sequences the OFM write-DMA path.
- Takes the 64-bit beat stream from the OFM buffer bank and turns it into AXI4 write bursts to DDR: issues AW, generates W/WLAST, counts B responses.
- Splits each transfer into bursts of at most MAX_BURST beats that never cross a 4 KB boundary.
- Gives the layer controller busy/done/err status.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 64, beat width; 8 bytes per beat.
- MAX_BURST, 16, maximum beats per burst (1..256).
- MAX_OUTSTANDING, 4, maximum AW bursts issued without a B response.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- ap_start  in  1  level start; rising edge launches a transfer
- base_addr  in  ADDR_W  DDR byte address, 8-byte aligned
- transfer_byte  in  32  bytes to write; low 3 bits ignored
- s_valid  in  1  upstream beat valid
- s_data  in  DATA_W  upstream beat
- s_ready  out  1  upstream beat accepted
- m_awvalid  out  1  AXI AW valid
- m_awready  in  1  AXI AW ready
- m_awaddr  out  ADDR_W  burst start address
- m_awlen  out  8  beats minus 1
- m_wvalid  out  1  AXI W valid
- m_wready  in  1  AXI W ready
- m_wdata  out  DATA_W  AXI W data
- m_wlast  out  1  last beat of burst
- m_bvalid  in  1  AXI B valid
- m_bready  out  1  AXI B ready; tied 1 while busy
- m_bresp  in  2  AXI B response
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when transfer finished
- err  out  1  sticky error flag

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all counters 0.
- Start:
  - Rising edge of ap_start in IDLE: latch base_addr and beats = transfer_byte>>3; set busy; clear err.
  - Rising edges while busy are ignored.
  - If beats == 0: go to FIN the next cycle. No AXI traffic.
- FSM states: IDLE -> CALC -> ADDR -> DATA -> (CALC | WAITB) -> FIN -> IDLE.
- CALC (1 cycle): len = min(MAX_BURST, remaining beats, (4096 - addr[11:0])>>3). Register awaddr/awlen.
- ADDR:
  - Hold m_awvalid=1 with awaddr/awlen stable until m_awready.
  - Do not assert m_awvalid while outstanding == MAX_OUTSTANDING.
  - On handshake: outstanding+1; addr += len*8; remaining -= len.
- DATA:
  - m_wvalid = s_valid; s_ready = m_wready; m_wdata = s_data. Pass-through, zero latency.
  - Beat counter increments on s_valid&m_wready.
  - m_wlast=1 when beat counter == awlen.
  - After the last-beat handshake: go to CALC if remaining > 0, else WAITB.
  - Outside DATA, s_ready=0 and m_wvalid=0.
- B channel:
  - Each m_bvalid&m_bready decrements outstanding. Accepted in any non-IDLE state.
  - A simultaneous AW handshake and B response leaves outstanding unchanged.
  - m_bresp != 0 sets err.
- WAITB: stay until outstanding == 0, then FIN.
- FIN: done=1 for exactly one cycle; busy=0 the next cycle; return to IDLE.
- Width rules:
  - Address arithmetic is ADDR_W bits and wraps modulo 2^ADDR_W. No check.
  - remaining is 29 bits.
  - outstanding is clog2(MAX_OUTSTANDING+1) bits and never under- or overflows. An unsolicited B while outstanding == 0 is ignored and sets err.
- Reset mid-transfer: every state, counter and output returns to its reset value in the next cycle. Partial bursts are abandoned.

Optional Feature:
OFM_WDMA_PERF_CNT_EN
- Defined: adds outputs perf_cycles[31:0] and perf_stall[31:0].
  - perf_cycles counts cycles while busy.
  - perf_stall counts cycles in DATA with s_valid & !m_wready, or in ADDR with m_awvalid & !m_awready.
  - Both clear on start and saturate at 0xFFFFFFFF.
- Undefined: neither port nor its logic exists. All other behaviour is identical.

Test Plan:
1. base_addr=0x1000_0000, transfer_byte=1024 (128 beats), always-ready slave -> 8 AW with awlen=15 at addresses +0x80 apart; 128 W beats with wlast every 16th; 8 B; done pulse once; busy low afterwards.
2. base_addr=0x1000_0FC0, transfer_byte=640 -> AW1 addr 0x...0FC0 len=7 (stops at the 4 KB boundary); then len 15,15,15,15,7 at 0x1000_1000 onward; wlast positions match each awlen.
3. transfer_byte=200 (25 beats) -> bursts of len 15 then 8; transfer_byte=0 -> done 2 cycles after start, no awvalid.
4. B responses withheld, MAX_OUTSTANDING=4, 8 bursts -> m_awvalid stays low after the 4th AW until the first B; then resumes; done only after the 8th B.
5. Random s_valid/m_wready gaps, plus bresp=2 on burst 3 -> data order preserved beat-for-beat; err=1 and held through done; err cleared by the next start.
6. rst_n low for one cycle mid-burst during DATA -> next cycle: all outputs 0, FSM IDLE; a new start then completes a 64-byte transfer cleanly.
